// File: rtl/irq_req_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_req_pkg : shared channel state type and default sizing constants        |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
package irq_req_pkg;

  localparam int NCH     = 16;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_LOW = 2'd2
  } chan_state_e;

endpackage : irq_req_pkg
`default_nettype wire

// File: rtl/irq_req_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_req_chan : one interrupt channel (EOI sync, FSM, event count, flags)   |
// | Option       : IRQ_REQ_TIMEOUT_EN adds a bounded wait in ASSERT            |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module irq_req_chan #(
  parameter int CNT_W   = irq_req_pkg::CNT_W,
  parameter int TIMEOUT = irq_req_pkg::TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_evt,
  input  logic i_mask,
  input  logic i_eoi_async,
  input  logic i_clr_err,
  output logic o_irq,
  output logic o_overflow,
  output logic o_timeout
);
  import irq_req_pkg::*;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  if (CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
    $error("irq_req_chan: CNT_W and TIMEOUT must be at least 1");
  end

  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             r_overflow;
  logic             w_eoi_rise;
  logic             w_eoi_low;
  logic             w_start;
  logic             w_ovf_set;
  logic             w_tmo_hit;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_eoi_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_eoi_rise = r_sync2 & ~r_sync3;
  assign w_eoi_low  = ~r_sync2;
  assign w_start    = (r_state == IDLE) && ((r_pend != '0) || i_evt) && !i_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = ASSERT;
      end
      ASSERT: begin
        // An acknowledge arriving on the expiry cycle is honoured, not flagged.
        if (w_eoi_rise)     w_state_nxt = WAIT_LOW;
        else if (w_tmo_hit) w_state_nxt = IDLE;
      end
      WAIT_LOW: begin
        if (w_eoi_low) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The event that launches an assertion is consumed by it; otherwise it is queued.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_set  = 1'b0;
    if (w_start) begin
      if (!i_evt) w_pend_nxt = r_pend - 1'b1;
    end else if (i_evt) begin
      if (r_pend == PEND_MAX) w_ovf_set  = 1'b1;
      else                    w_pend_nxt = r_pend + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_overflow <= w_ovf_set | (r_overflow & ~i_clr_err);
    end
  end

`ifdef IRQ_REQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;

  // Held at zero outside ASSERT so every entry starts a fresh wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ASSERT) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_state == ASSERT) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (w_tmo_hit & ~w_eoi_rise) | (r_timeout & ~i_clr_err);
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_irq      = (r_state == ASSERT);
  assign o_overflow = r_overflow;

endmodule : irq_req_chan
`default_nettype wire

// File: rtl/irq_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_requester : NCH independent level-interrupt requesters with EOI hshake |
// | Option        : IRQ_REQ_TIMEOUT_EN enables the per-channel EOI timeout     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module irq_requester #(
  parameter int NCH     = irq_req_pkg::NCH,
  parameter int CNT_W   = irq_req_pkg::CNT_W,
  parameter int TIMEOUT = irq_req_pkg::TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] evt,
  input  logic [NCH-1:0] mask,
  input  logic [NCH-1:0] eoi_async,
  input  logic           clr_err,
  output logic [NCH-1:0] irq,
  output logic [NCH-1:0] overflow,
  output logic [NCH-1:0] timeout
);
  import irq_req_pkg::*;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    irq_req_chan #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .i_evt       (evt[gi]),
      .i_mask      (mask[gi]),
      .i_eoi_async (eoi_async[gi]),
      .i_clr_err   (clr_err),
      .o_irq       (irq[gi]),
      .o_overflow  (overflow[gi]),
      .o_timeout   (timeout[gi])
    );
  end

endmodule : irq_requester
`default_nettype wire

// File: doc/irq_requester.md
IRQ_REQUESTER -- requirements
Module: irq_requester

Interface
REQ-001 SHALL have parameter NCH, default 16: number of interrupt channels.
REQ-002 SHALL have parameter CNT_W, default 2: width of each channel's pending-event counter.
REQ-003 SHALL have parameter TIMEOUT, default 1024: cycles allowed in ASSERT before timeout (used only with IRQ_REQ_TIMEOUT_EN).
REQ-004 SHALL have ports, one per line:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-high reset
  evt  in  NCH  single-cycle event pulses from local logic, one per channel
  mask  in  NCH  1 = channel may not start a new irq assertion
  eoi_async  in  NCH  end-of-interrupt lines from pads, asynchronous to clk
  clr_err  in  1  single-cycle pulse that clears all sticky error flags
  irq  out  NCH  level interrupt requests to pads
  overflow  out  NCH  sticky: event arrived while the counter was saturated
  timeout  out  NCH  sticky: the EOI wait expired

Function
REQ-005 Each channel SHALL synchronise eoi_async[i] through two flops, then detect a rising edge with a third flop.
REQ-006 Each channel SHALL run an FSM with states IDLE, ASSERT and WAIT_LOW.
REQ-007 In IDLE, with (pend>0 or evt[i]) and mask[i]=0, the FSM SHALL go to ASSERT and set pend := pend + evt[i] - 1.
REQ-008 irq[i] SHALL be 1 exactly while the FSM is in ASSERT.
REQ-009 An evt[i] sampled at edge n in IDLE, with pend=0 and mask[i]=0, SHALL drive irq[i] high after edge n.
REQ-010 In ASSERT, a synchronised EOI rising edge SHALL move the FSM to WAIT_LOW.
REQ-011 Because of REQ-010, irq[i] SHALL fall after the third clk edge at which eoi_async[i] is sampled high (that sampling edge counts as the first).
REQ-012 An EOI rising edge seen in IDLE or WAIT_LOW SHALL be ignored.
REQ-013 In WAIT_LOW, the FSM SHALL go to IDLE once synchronised EOI is 0.
REQ-014 Any new assertion SHALL then be governed by REQ-007, so back-to-back assertions are always separated by at least 2 cycles with irq low.
REQ-015 Outside the IDLE->ASSERT transition, evt[i] SHALL increment pend.
REQ-016 pend SHALL saturate at 2^CNT_W-1.
REQ-017 An evt[i] at saturation SHALL be dropped and SHALL set overflow[i].
REQ-018 A simultaneous evt and EOI edge SHALL both take effect in the same cycle: the count increments and the FSM moves to WAIT_LOW.
REQ-019 mask[i] SHALL gate only the IDLE->ASSERT transition.
REQ-020 Raising mask[i] SHALL NOT deassert an active irq[i]; events SHALL still be counted while mask[i]=1.
REQ-021 clr_err SHALL clear overflow and timeout on the next edge.
REQ-022 If clr_err coincides with a new error, the set SHALL win.
REQ-023 Channels SHALL be fully independent.

Reset
REQ-024 rst=1 SHALL asynchronously force all FSMs to IDLE, pend to 0, synchroniser flops to 0, irq to 0, overflow to 0 and timeout to 0.
REQ-025 Reset asserted mid-ASSERT SHALL drop irq immediately and discard all pending events.
REQ-026 After rst deasserts, the first evt SHALL be honoured on the first clk edge.

Configuration
REQ-027 With macro IRQ_REQ_TIMEOUT_EN defined, each channel SHALL count cycles spent in ASSERT.
REQ-028 With IRQ_REQ_TIMEOUT_EN defined, when that count reaches TIMEOUT the FSM SHALL go to IDLE (irq falls), keep pend, and set timeout[i]; the count SHALL restart on each ASSERT entry.
REQ-029 Without IRQ_REQ_TIMEOUT_EN, there SHALL be no counter logic, timeout SHALL be tied to 0, and ASSERT SHALL wait indefinitely.

Structure
REQ-030 Package irq_req_pkg SHALL hold the chan_state_e enum (IDLE, ASSERT, WAIT_LOW) and the default constants NCH, CNT_W and TIMEOUT.
REQ-031 Sub-module irq_req_chan SHALL implement one channel: synchroniser, FSM, counter, flags and optional timeout.
REQ-032 irq_requester SHALL instantiate NCH copies of irq_req_chan in a generate loop and share clr_err across them.

Verification
REQ-033 Bench SHALL cover: evt[3] pulse at edge 10 -> irq[3]=1 after edge 10; eoi_async[3] high at edge 20 -> irq[3]=0 after edge 22; eoi low -> back to IDLE.
REQ-034 Bench SHALL cover: 4 evt[0] pulses while irq[0] is high (CNT_W=2) -> 3 counted, overflow[0]=1; exactly 3 further irq assertions follow as EOI is cycled.
REQ-035 Bench SHALL cover: mask[5]=1 with 2 evt[5] pulses -> irq[5] stays 0; clearing mask -> 2 assertions follow; raising mask during ASSERT leaves irq high until EOI.
REQ-036 Bench SHALL cover: evt[7] in the same cycle as the EOI-detect edge -> WAIT_LOW; after EOI falls, irq re-asserts once.
REQ-037 Bench SHALL cover: rst pulse mid-ASSERT with pend=2 -> irq=0 immediately, no further assertions without new evt.
REQ-038 Bench SHALL cover, with IRQ_REQ_TIMEOUT_EN and TIMEOUT=16: no EOI -> irq falls after 16 cycles and timeout=1; clr_err -> timeout=0.
